multicycle_control_unit: RTL and testbench

- Sequential successor to the single-cycle opcode decoder; sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath write enables as one-cycle strobes; handshakes with instruction/data memory (req/ready).
- Parametrised opcode width and memory-wait timeout; flags illegal opcodes and memory timeouts.
- Sits between the instruction register/memory interface and the register file/ALU/PC datapath.

---
 rtl/mmips_ctrl_pkg.sv | 38 +++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/multicycle_control_unit.sv | 155 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-style control unit:
// FSM state codes, opcode encodings and PC-source select codes.
package mmips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_LUI  = 4'b0111;
    localparam logic [3:0] OP_BR   = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;
    localparam logic [3:0] OP_JR   = 4'b1100;
    localparam logic [3:0] OP_JAL  = 4'b1101;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // The defined encodings form one contiguous range, ADD through JAL.
    function automatic logic op_is_defined(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_JAL);
    endfunction

    function automatic logic op_uses_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory handshake; expired flags the
// final permitted cycle so the FSM can abort on that same cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    assign expired = enable && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: walks each instruction through FETCH/DECODE/EXEC/
// MEM/WB and emits datapath strobes plus memory request/handshake controls.
module multicycle_control_unit
    import mmips_ctrl_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           branch_taken,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           ir_we,
    output logic           pc_we,
    output logic [1:0]     is_jump,
    output logic           alu_op_b,
    output logic           we_reg_mem,
    output logic           illegal_op,
    output logic           mem_err,
    output logic [2:0]     state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opc_q;
    logic       wait_active;
    logic       timer_clear;
    logic       timer_expired;
    logic       illegal_now;

    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timer_clear = !wait_active || mem_ready || timer_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (wait_active),
        .expired (timer_expired)
    );

    // Upper opcode bits beyond the 4-bit encoding space must all be zero.
    assign illegal_now = ((opcode >> 4) != '0) || !op_is_defined(opcode[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                opc_q <= opcode[3:0];
            end
        end
    end

    // Outputs decode from state and latched opcode; only the strobes react
    // to mem_ready/branch_taken within the cycle. mem_req is gated by rst_n
    // so a pending request is dropped the instant reset asserts.
    always_comb begin
        state_d    = ST_FETCH;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        is_jump    = PCSRC_SEQ;
        alu_op_b   = 1'b0;
        we_reg_mem = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = rst_n;
                state_d = ST_FETCH;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    mem_err = 1'b1;
                end
            end

            ST_DECODE: begin
                if (illegal_now) begin
                    illegal_op = 1'b1;
                    pc_we      = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_op_b = op_uses_imm(opc_q);
                state_d  = ST_WB;
                case (opc_q)
                    OP_LW, OP_SW: state_d = ST_MEM;
                    OP_BR: begin
                        pc_we   = 1'b1;
                        is_jump = branch_taken ? PCSRC_BR : PCSRC_SEQ;
                        state_d = ST_FETCH;
                    end
                    OP_J, OP_JR: begin
                        pc_we   = 1'b1;
                        is_jump = PCSRC_JMP;
                        state_d = ST_FETCH;
                    end
                    OP_JAL: begin
                        pc_we   = 1'b1;
                        is_jump = PCSRC_JMP;
                        state_d = ST_WB;
                    end
                    default: state_d = ST_WB;
                endcase
            end

            ST_MEM: begin
                mem_req = rst_n;
                mem_we  = rst_n && (opc_q == OP_SW);
                state_d = ST_MEM;
                if (mem_ready) begin
                    if (opc_q == OP_SW) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timer_expired) begin
                    mem_err = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_WB: begin
                we_reg_mem = 1'b1;
                pc_we      = (opc_q != OP_JAL);
                state_d    = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench: each step queues inputs plus the expected
// output vector, then the queue is drained one clock cycle per entry.
module tb_multicycle_control_unit;

    localparam int OPW     = 4;
    localparam int TIMEOUT = 4;
    localparam int TW      = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [OPW-1:0] opcode;
    logic           branch_taken;
    logic           mem_ready;
    logic           mem_req;
    logic           mem_we;
    logic           ir_we;
    logic           pc_we;
    logic [1:0]     is_jump;
    logic           alu_op_b;
    logic           we_reg_mem;
    logic           illegal_op;
    logic           mem_err;
    logic [2:0]     state;

    multicycle_control_unit #(
        .OPW     (OPW),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .is_jump      (is_jump),
        .alu_op_b     (alu_op_b),
        .we_reg_mem   (we_reg_mem),
        .illegal_op   (illegal_op),
        .mem_err      (mem_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic       rdy;
        logic       bt;
    } stim_t;

    stim_t       stim_q[$];
    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [13:0] obs;

    assign obs = {state, mem_req, mem_we, ir_we, pc_we, is_jump,
                  alu_op_b, we_reg_mem, illegal_op, mem_err};

    // Packs {state, req, we, ir, pc, jump, imm, wreg, illegal, err}.
    function automatic logic [13:0] ev(input logic [2:0] st, input logic req,
            input logic we, input logic ir, input logic pc, input logic [1:0] j,
            input logic ab, input logic wr, input logic ill, input logic err);
        return {st, req, we, ir, pc, j, ab, wr, ill, err};
    endfunction

    task automatic apply_stimulus(input logic [3:0] op, input logic rdy,
            input logic bt, input logic [13:0] e, input string tag);
        stim_t s;
        s.op  = op;
        s.rdy = rdy;
        s.bt  = bt;
        stim_q.push_back(s);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_vec(input string tag, input logic [13:0] o,
            input logic [13:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Entered on a falling edge: drive, settle, compare, advance one cycle.
    task automatic check_output();
        stim_t       s;
        logic [13:0] e;
        string       t;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            opcode       = s.op;
            mem_ready    = s.rdy;
            branch_taken = s.bt;
            #1;
            check_vec(t, obs, e);
            @(negedge clk);
        end
    endtask

    task automatic fetch_ok(input string tag);
        apply_stimulus(4'hF, 1'b1, 1'b0, ev(3'd0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0), tag);
    endtask

    task automatic decode_ok(input logic [3:0] op, input string tag);
        apply_stimulus(op, 1'b0, 1'b0, ev(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        opcode       = '0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        #1;
        check_vec("reset_hold", obs, ev(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("reset_release", obs, ev(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));

        // addi, zero-wait fetch; mem_ready in WB must be ignored
        fetch_ok("addi_fetch");
        decode_ok(4'b0100, "addi_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0), "addi_exec");
        apply_stimulus(4'hF, 1, 0, ev(3'd4, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0), "addi_wb");
        check_output();

        // sw with ready arriving on the final permitted MEM cycle
        fetch_ok("sw_fetch");
        decode_ok(4'b0110, "sw_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "sw_exec");
        for (int i = 0; i < 3; i++)
            apply_stimulus(4'hF, 0, 0, ev(3'd3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0), "sw_mem_wait");
        apply_stimulus(4'hF, 1, 0, ev(3'd3, 1, 1, 0, 1, 2'b00, 0, 0, 0, 0), "sw_mem_ready");
        check_output();

        // branch taken, then not taken
        fetch_ok("br_t_fetch");
        decode_ok(4'b1000, "br_t_decode");
        apply_stimulus(4'hF, 0, 1, ev(3'd2, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0), "br_t_exec");
        fetch_ok("br_n_fetch");
        decode_ok(4'b1000, "br_n_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), "br_n_exec");
        check_output();

        // jal: PC written in EXEC, link write in WB without a second pc_we
        fetch_ok("jal_fetch");
        decode_ok(4'b1101, "jal_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0), "jal_exec");
        apply_stimulus(4'hF, 0, 0, ev(3'd4, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0), "jal_wb");
        check_output();

        // illegal opcode skips straight back to FETCH
        fetch_ok("ill_fetch");
        apply_stimulus(4'b1111, 0, 0, ev(3'd1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0), "ill_decode");
        // j: jump select regardless of branch_taken
        fetch_ok("j_fetch");
        decode_ok(4'b1001, "j_decode");
        apply_stimulus(4'hF, 0, 1, ev(3'd2, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0), "j_exec");
        check_output();

        // lw, zero-wait data memory
        fetch_ok("lw_fetch");
        decode_ok(4'b0101, "lw_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "lw_exec");
        apply_stimulus(4'hF, 1, 0, ev(3'd3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "lw_mem");
        apply_stimulus(4'hF, 0, 0, ev(3'd4, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0), "lw_wb");
        check_output();

        // lw timing out in MEM: dropped, PC advances, no register write
        fetch_ok("lwto_fetch");
        decode_ok(4'b0101, "lwto_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "lwto_exec");
        for (int i = 0; i < 3; i++)
            apply_stimulus(4'hF, 0, 0, ev(3'd3, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "lwto_wait");
        apply_stimulus(4'hF, 0, 0, ev(3'd3, 1, 0, 0, 1, 2'b00, 0, 0, 0, 1), "lwto_expire");
        check_output();

        // FETCH timeout, counter restart, then ready on the expiry cycle
        for (int i = 0; i < 3; i++)
            apply_stimulus(4'hF, 0, 0, ev(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "fto_wait");
        apply_stimulus(4'hF, 0, 0, ev(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1), "fto_expire");
        for (int i = 0; i < 3; i++)
            apply_stimulus(4'hF, 0, 0, ev(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0), "fto_restart");
        fetch_ok("fto_ready_on_expiry");
        decode_ok(4'b0011, "add_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "add_exec");
        apply_stimulus(4'hF, 0, 0, ev(3'd4, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0), "add_wb");
        check_output();

        // reset asserted while a store is waiting in MEM
        fetch_ok("sw2_fetch");
        decode_ok(4'b0110, "sw2_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "sw2_exec");
        apply_stimulus(4'hF, 0, 0, ev(3'd3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0), "sw2_mem_wait");
        check_output();
        mem_ready = 1'b0;
        #1;
        check_vec("sw2_mem_pre_reset", obs, ev(3'd3, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("reset_async_mid_mem", obs, ev(3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("reset_release_mid", obs, ev(3'd0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        fetch_ok("post_reset_fetch");
        decode_ok(4'b0111, "post_reset_decode");
        apply_stimulus(4'hF, 0, 0, ev(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "lui_exec");
        apply_stimulus(4'hF, 0, 0, ev(3'd4, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0), "lui_wb");
        check_output();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
